event_arbiter: RTL and testbench

- Shares one event-sampling register stage between several requesters. Each requester owns the stage for a bounded burst under a req/gnt handshake.
- While a requester is granted, its event bit is registered (ev_q). A 3-bit status code is derived from the registered bit one cycle later: 3'b010 if it was 1, 3'b011 if it was 0.
- Round-robin fairness, a hold-time limit and a forced dead cycle between owners.

---
 rtl/event_arbiter_pkg.sv | 15 +
 rtl/event_arbiter_rr_pick.sv | 36 +++
 rtl/event_arbiter.sv | 127 ++++++++++++
 tb/tb_event_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/event_arbiter_pkg.sv
// event_arbiter_pkg
//   Shared definitions for the event arbiter slice: FSM state encodings and
//   the status code values produced from the registered event bit.
package event_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [2:0] CODE_EV1 = 3'b010;
  localparam logic [2:0] CODE_EV0 = 3'b011;

endpackage

// File: rtl/event_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Starting one position past rr_last
//   and wrapping modulo N_REQ, returns the first requester whose req bit is
//   set. Equivalent to rotate / priority-encode / un-rotate.
// Ports:
//   req     - per-requester request levels
//   rr_last - index of the most recent winner
//   valid   - at least one request is pending
//   winner  - selected requester index (0 when valid is low)
module rr_pick
  import event_arbiter_pkg::*;
#(
  parameter int IDX_W = 2,
  localparam int N_REQ = 1 << IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Walk from the farthest candidate (rr_last itself) toward the nearest
  // (rr_last+1); the last hit written is therefore the closest one after
  // rr_last, which gives round-robin priority without a loop break.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx    = '0;
    winner = '0;
    valid  = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = rr_last + IDX_W'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/event_arbiter.sv
// event_arbiter
//   Shares one event-sampling register stage among N_REQ requesters with a
//   req/gnt handshake. Round-robin selection, a HOLD_MAX cycle grant limit
//   and one forced dead cycle (GAP) between owners.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset
//   req     - per-requester request levels
//   ev      - per-requester event bits
//   gnt     - one-hot registered grant, zero when there is no owner
//   owner   - index of current or most recent owner
//   busy    - high while in GRANT
//   timeout - one-cycle pulse when a grant is revoked at HOLD_MAX
//   ev_q    - registered ev[owner] while granted, 0 otherwise
//   code    - CODE_EV1 if ev_q was 1 on the previous edge, else CODE_EV0
module event_arbiter
  import event_arbiter_pkg::*;
#(
  parameter int IDX_W    = 2,
  parameter int HOLD_MAX = 8,
  localparam int N_REQ   = 1 << IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] ev,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             timeout,
  output logic             ev_q,
  output logic [2:0]       code
);

  state_t           state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] owner_n;
  logic [IDX_W-1:0] rr_last, rr_last_n;
  logic [7:0]       cnt, cnt_n;
  logic             timeout_n;
  logic             ev_q_n;
  logic [2:0]       code_n;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_winner;

  rr_pick #(.IDX_W(IDX_W)) u_pick (
    .req     (req),
    .rr_last (rr_last),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  // Next-state and next-output logic. Release by the owner takes priority
  // over the hold limit, so a drop on the last allowed cycle is a normal
  // release with no timeout pulse.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    rr_last_n = rr_last;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_n              = '0;
          gnt_n[pick_winner] = 1'b1;
          owner_n            = pick_winner;
          rr_last_n          = pick_winner;
          cnt_n              = 8'd1;
          state_n            = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner]) begin
          gnt_n   = '0;
          state_n = ST_GAP;
        end else if (cnt == 8'(HOLD_MAX)) begin
          gnt_n     = '0;
          timeout_n = 1'b1;
          state_n   = ST_GAP;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_GAP: begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    // The sampling stage follows the owner on every GRANT edge, including
    // the releasing one; code is a fixed one-cycle lag of ev_q.
    ev_q_n = (state == ST_GRANT) ? ev[owner] : 1'b0;
    code_n = ev_q ? CODE_EV1 : CODE_EV0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      owner   <= '0;
      rr_last <= IDX_W'(N_REQ - 1);
      cnt     <= '0;
      timeout <= 1'b0;
      ev_q    <= 1'b0;
      code    <= CODE_EV0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      rr_last <= rr_last_n;
      cnt     <= cnt_n;
      timeout <= timeout_n;
      ev_q    <= ev_q_n;
      code    <= code_n;
    end
  end

  assign busy = (state == ST_GRANT);

endmodule

// File: tb/tb_event_arbiter.sv
// tb_event_arbiter
//   Directed bench for event_arbiter (IDX_W=2, HOLD_MAX=8). Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
module tb_event_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] ev;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic       ev_q;
  logic [2:0] code;

  int checks;
  int errors;

  event_arbiter #(.IDX_W(2), .HOLD_MAX(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .ev      (ev),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout),
    .ev_q    (ev_q),
    .code    (code)
  );

  // Free-running clock, 10 time unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset with requests idle, used to start each scenario clean.
  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    ev    = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  // Two reset cycles with every requester asking; nothing may be granted.
  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    ev    = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt cyc %0d got %b want 0000", c, gnt); end
      checks++;
      if (ev_q !== 1'b0) begin errors++; $display("[TB] FAIL reset_evq cyc %0d got %b want 0", c, ev_q); end
      checks++;
      if (code !== 3'b011) begin errors++; $display("[TB] FAIL reset_code cyc %0d got %b want 011", c, code); end
      checks++;
      if (owner !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner cyc %0d got %0d want 0", c, owner); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy cyc %0d got %b want 0", c, busy); end
    end
    reset = 1'b0;
    req   = 4'b0000;
    ev    = 4'b0000;
  endtask

  // Single requester 2: one-cycle grant latency, ev pipeline, release, gap.
  task automatic test_first_grant();
    req = 4'b0100;
    ev  = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL first_gnt got %b want 0100", gnt); end
    checks++;
    if (owner !== 2'd2) begin errors++; $display("[TB] FAIL first_owner got %0d want 2", owner); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy got %b want 1", busy); end
    tick();
    checks++;
    if (ev_q !== 1'b1) begin errors++; $display("[TB] FAIL first_evq got %b want 1", ev_q); end
    checks++;
    if (code !== 3'b011) begin errors++; $display("[TB] FAIL first_code_lag got %b want 011", code); end
    req = 4'b0000;
    ev  = 4'b0000;
    tick();
    checks++;
    if (code !== 3'b010) begin errors++; $display("[TB] FAIL first_code got %b want 010", code); end
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL first_release got %b want 0000", gnt); end
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL first_timeout got %b want 0", timeout); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL first_gap cyc %0d got %b want 0000", c, gnt); end
    end
  endtask

  // All four requesting: owners 0,1,2,3,0, each revoked at HOLD_MAX.
  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      checks++;
      if (gnt !== exp_gnt) begin errors++; $display("[TB] FAIL rr_gnt grant %0d got %b want %b", k, gnt, exp_gnt); end
      checks++;
      if (owner !== 2'(k % 4)) begin errors++; $display("[TB] FAIL rr_owner grant %0d got %0d want %0d", k, owner, k % 4); end
      if (k == 4) break;
      for (int c = 2; c <= 8; c++) begin
        tick();
        checks++;
        if (gnt !== exp_gnt || timeout !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rr_hold grant %0d cyc %0d got gnt %b to %b want gnt %b to 0", k, c, gnt, timeout, exp_gnt);
        end
      end
      tick();
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_revoke grant %0d got gnt %b to %b want gnt 0000 to 1", k, gnt, timeout);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_idle grant %0d got gnt %b to %b want gnt 0000 to 0", k, gnt, timeout);
      end
    end
    req = 4'b0000;
  endtask

  // Owner 1 drops req on its 8th granted cycle: plain release, no timeout.
  task automatic test_boundary_release();
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) tick();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL bnd_gnt8 got %b want 0010", gnt); end
    req = 4'b0000;
    tick();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL bnd_timeout got %b want 0", timeout); end
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bnd_gap got gnt %b busy %b want 0000 0", gnt, busy); end
    tick();
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bnd_idle got to %b busy %b want 0 0", timeout, busy); end
  endtask

  // Owner 3 with ev[3]=0 while others have ev=1; req[0] toggles meanwhile.
  task automatic test_isolation();
    do_reset();
    req = 4'b1000;
    ev  = 4'b0111;
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL iso_gnt cyc %0d got %b want 1000", c, gnt); end
      checks++;
      if (ev_q !== 1'b0 || code !== 3'b011) begin
        errors++;
        $display("[TB] FAIL iso_evq cyc %0d got ev_q %b code %b want 0 011", c, ev_q, code);
      end
      req[0] = ~req[0];
      tick();
    end
    req = 4'b0000;
    ev  = 4'b0000;
    tick();
  endtask

  // Reset on grant cycle 3 to requester 2; rr_last must return to 3.
  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    ev  = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL mid_gnt got %b want 0100", gnt); end
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (ev_q !== 1'b1) begin errors++; $display("[TB] FAIL mid_evq got %b want 1", ev_q); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL mid_rst_gnt got %b want 0000", gnt); end
    checks++;
    if (code !== 3'b011) begin errors++; $display("[TB] FAIL mid_rst_code got %b want 011", code); end
    checks++;
    if (timeout !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_rst_state got to %b owner %0d want 0 0", timeout, owner);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_regrant got %b want 0001", gnt); end
    req = 4'b0000;
    ev  = 4'b0000;
  endtask

  // Run the scenarios in sequence and print the summary.
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    ev     = 4'b0000;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_boundary_release();
    test_isolation();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
